// File: rtl/prog_loader_if.sv
// Word-stream and instruction-memory write bundle shared by the program loader and its neighbours.
interface prog_loader_if #(
  parameter int DATAW = 32,
  parameter int ADDRW = 12
);
  logic [DATAW-1:0] din;
  logic             valid;
  logic             restart;
  logic             we;
  logic [ADDRW-1:0] waddr;
  logic [DATAW-1:0] wdata;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output din, valid, restart,
    input  we, waddr, wdata, busy, done, err
  );

  modport slave (
    input  din, valid, restart,
    output we, waddr, wdata, busy, done, err
  );
endinterface

// File: rtl/prog_loader.sv
// Length-prefixed program image loader: first word is N, next N words go to imem addresses 0..N-1.
// Optional trailing checksum word is enabled with `define PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int DATAW = 32,
  parameter int ADDRW = 12
) (
  input  logic         clk,
  input  logic         rst,
  prog_loader_if.slave bus
);

  localparam int CW = ADDRW + 1;
  localparam logic [DATAW-1:0] CAP = DATAW'(1) << ADDRW;

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;

  state_t           state_p0, state_nx;
  logic [CW-1:0]    cnt_p0, cnt_nx;
  logic [CW-1:0]    rem_p0, rem_nx;
  logic             we_nx;
  logic [ADDRW-1:0] waddr_nx;
  logic [DATAW-1:0] wdata_nx;
  logic             busy_nx, done_nx, err_nx;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DATAW-1:0] acc_p0, acc_nx;
`endif

  function automatic logic oversize(input logic [DATAW-1:0] n);
    return n > CAP;
  endfunction

  always_comb begin
    state_nx = state_p0;
    cnt_nx   = cnt_p0;
    rem_nx   = rem_p0;
    we_nx    = 1'b0;
    waddr_nx = bus.waddr;
    wdata_nx = bus.wdata;
    err_nx   = bus.err;
`ifdef PROG_LOADER_CHECKSUM_EN
    acc_nx   = acc_p0;
`endif
    case (state_p0)
      IDLE: begin
        if (bus.valid) begin
          if (bus.din == '0) begin
            state_nx = DONE;
            err_nx   = 1'b0;
          end else if (oversize(bus.din)) begin
            state_nx = DONE;
            err_nx   = 1'b1;
          end else begin
            state_nx = LOAD;
            rem_nx   = bus.din[CW-1:0];
            cnt_nx   = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            acc_nx   = '0;
`endif
          end
        end
      end
      LOAD: begin
        if (bus.valid) begin
          we_nx    = 1'b1;
          waddr_nx = cnt_p0[ADDRW-1:0];
          wdata_nx = bus.din;
          cnt_nx   = cnt_p0 + CW'(1);
          rem_nx   = rem_p0 - CW'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
          acc_nx   = acc_p0 + bus.din;
`endif
          // Last payload word leaves LOAD in the same edge its write is issued.
          if (rem_p0 == CW'(1)) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_nx = CHECK;
`else
            state_nx = DONE;
`endif
            err_nx   = 1'b0;
          end
        end
      end
      CHECK: begin
`ifdef PROG_LOADER_CHECKSUM_EN
        if (bus.valid) begin
          state_nx = DONE;
          err_nx   = (bus.din != acc_p0);
        end
`else
        state_nx = IDLE;
`endif
      end
      DONE: begin
        // restart takes priority; a coincident valid word is dropped.
        if (bus.restart) begin
          state_nx = IDLE;
          err_nx   = 1'b0;
          cnt_nx   = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          acc_nx   = '0;
`endif
        end
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx == LOAD) || (state_nx == CHECK);
    done_nx = (state_nx == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_p0  <= IDLE;
      cnt_p0    <= '0;
      rem_p0    <= '0;
      bus.we    <= 1'b0;
      bus.waddr <= '0;
      bus.wdata <= '0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.err   <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      acc_p0    <= '0;
`endif
    end else begin
      state_p0  <= state_nx;
      cnt_p0    <= cnt_nx;
      rem_p0    <= rem_nx;
      bus.we    <= we_nx;
      bus.waddr <= waddr_nx;
      bus.wdata <= wdata_nx;
      bus.busy  <= busy_nx;
      bus.done  <= done_nx;
      bus.err   <= err_nx;
`ifdef PROG_LOADER_CHECKSUM_EN
      acc_p0    <= acc_nx;
`endif
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_prog_loader;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   nchk = 0;
  int   nerr = 0;

  prog_loader_if #(.DATAW(32), .ADDRW(12)) bus ();

  prog_loader #(.DATAW(32), .ADDRW(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        restart;
    logic [31:0] din;
    logic        we;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input logic r, input logic [31:0] d,
                              input logic we, input logic [11:0] wa, input logic [31:0] wd,
                              input logic b, input logic dn, input logic e);
    vec_t x;
    x.valid = v; x.restart = r; x.din = d;
    x.we = we; x.waddr = wa; x.wdata = wd;
    x.busy = b; x.done = dn; x.err = e;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic r, input logic [31:0] d);
    @(negedge clk);
    bus.valid   = v;
    bus.restart = r;
    bus.din     = d;
    @(posedge clk);
    #1;
    bus.valid   = 1'b0;
    bus.restart = 1'b0;
  endtask

  task automatic chk_flags(input string tag, input logic we, input logic b,
                           input logic dn, input logic e);
    chk({tag, ".we"},   {31'd0, bus.we},   {31'd0, we});
    chk({tag, ".busy"}, {31'd0, bus.busy}, {31'd0, b});
    chk({tag, ".done"}, {31'd0, bus.done}, {31'd0, dn});
    chk({tag, ".err"},  {31'd0, bus.err},  {31'd0, e});
  endtask

  task automatic chk_write(input string tag, input logic [11:0] a, input logic [31:0] d);
    chk({tag, ".we"},    {31'd0, bus.we}, 32'd1);
    chk({tag, ".waddr"}, {20'd0, bus.waddr}, {20'd0, a});
    chk({tag, ".wdata"}, bus.wdata, d);
  endtask

  int          gaps[5];
  logic [31:0] words[5];
  logic [31:0] sum;

  initial begin
    bus.valid   = 1'b0;
    bus.restart = 1'b0;
    bus.din     = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.waddr", {20'd0, bus.waddr}, 32'd0);
    chk("reset.wdata", bus.wdata, 32'd0);
    rst = 1'b1;

    // Per-cycle table: load 3 words, empty image, oversize image, restart priority
    tbl.push_back(mk(1, 0, 32'd3,    0, 0, 0,     1,   0,   0));
    tbl.push_back(mk(1, 0, 32'hA,    1, 0, 32'hA, 1,   0,   0));
    tbl.push_back(mk(1, 0, 32'hB,    1, 1, 32'hB, 1,   0,   0));
    tbl.push_back(mk(1, 0, 32'hC,    1, 2, 32'hC, CK, !CK,  0));
    tbl.push_back(mk(1, 0, 32'h21,   0, 0, 0,     0,   1,   0));
    tbl.push_back(mk(0, 0, 32'd0,    0, 0, 0,     0,   1,   0));
    tbl.push_back(mk(0, 1, 32'd0,    0, 0, 0,     0,   0,   0));
    tbl.push_back(mk(1, 0, 32'd0,    0, 0, 0,     0,   1,   0));
    tbl.push_back(mk(1, 0, 32'd5,    0, 0, 0,     0,   1,   0));
    tbl.push_back(mk(0, 1, 32'd0,    0, 0, 0,     0,   0,   0));
    tbl.push_back(mk(1, 0, 32'd4097, 0, 0, 0,     0,   1,   1));
    tbl.push_back(mk(1, 0, 32'd9,    0, 0, 0,     0,   1,   1));
    tbl.push_back(mk(1, 1, 32'd9,    0, 0, 0,     0,   0,   0));
    tbl.push_back(mk(1, 1, 32'd1,    0, 0, 0,     1,   0,   0));
    tbl.push_back(mk(1, 0, 32'h55,   1, 0, 32'h55, CK, !CK, 0));
    tbl.push_back(mk(1, 0, 32'h55,   0, 0, 0,     0,   1,   0));
    tbl.push_back(mk(0, 1, 32'd0,    0, 0, 0,     0,   0,   0));

    foreach (tbl[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      cyc(tbl[i].valid, tbl[i].restart, tbl[i].din);
      chk_flags(tag, tbl[i].we, tbl[i].busy, tbl[i].done, tbl[i].err);
      if (tbl[i].we) begin
        chk({tag, ".waddr"}, {20'd0, bus.waddr}, {20'd0, tbl[i].waddr});
        chk({tag, ".wdata"}, bus.wdata, tbl[i].wdata);
      end
    end

    // Asynchronous reset in the middle of a 4-word load
    cyc(1, 0, 32'd4);
    cyc(1, 0, 32'h11);
    cyc(1, 0, 32'h22);
    chk_write("abort.pre", 12'd1, 32'h22);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk_flags("abort.async", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort.waddr", {20'd0, bus.waddr}, 32'd0);
    chk("abort.wdata", bus.wdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cyc(1, 0, 32'd1);
    chk_flags("relen", 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1, 0, 32'h7);
    chk_write("reload", 12'd0, 32'h7);
    chk("reload.done", {31'd0, bus.done}, {31'd0, !CK});
`ifdef PROG_LOADER_CHECKSUM_EN
    cyc(1, 0, 32'h7);
    chk_flags("reload.ck", 1'b0, 1'b0, 1'b1, 1'b0);
`endif
    cyc(0, 1, 32'd0);

    // Gapped valids for a 5-word image
    gaps  = '{0, 3, 1, 5, 2};
    words = '{32'hDEAD0001, 32'h12345678, 32'h0, 32'hFFFFFFFF, 32'hCAFEF00D};
    sum = '0;
    cyc(1, 0, 32'd5);
    for (int i = 0; i < 5; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        cyc(0, 0, 32'd0);
        chk_flags($sformatf("gap%0d_%0d", i, g), 1'b0, 1'b1, 1'b0, 1'b0);
      end
      cyc(1, 0, words[i]);
      sum += words[i];
      chk_write($sformatf("gapw%0d", i), 12'(i), words[i]);
      chk($sformatf("gapw%0d.done", i), {31'd0, bus.done}, {31'd0, (i == 4) && !CK});
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    cyc(1, 0, sum);
    chk_flags("gap.ck", 1'b0, 1'b0, 1'b1, 1'b0);
`endif
    cyc(0, 1, 32'd0);

    // Full-capacity image: addresses 0..4095 without wrap
    sum = '0;
    cyc(1, 0, 32'd4096);
    chk_flags("full.len", 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4096; i++) begin
      cyc(1, 0, 32'(i * 3 + 1));
      sum += 32'(i * 3 + 1);
      chk($sformatf("full%0d.waddr", i), {19'd0, bus.we, bus.waddr}, {19'd0, 1'b1, 12'(i)});
    end
    chk("full.wdata", bus.wdata, 32'(4095 * 3 + 1));
    chk_flags("full.end", 1'b1, CK, !CK, 1'b0);
`ifdef PROG_LOADER_CHECKSUM_EN
    cyc(1, 0, sum);
    chk_flags("full.ck", 1'b0, 1'b0, 1'b1, 1'b0);
`endif
    cyc(0, 1, 32'd0);

`ifdef PROG_LOADER_CHECKSUM_EN
    // Checksum match and mismatch; the checksum word is never written
    for (int k = 0; k < 2; k++) begin
      cyc(1, 0, 32'd2);
      cyc(1, 0, 32'd1);
      chk_write($sformatf("ck%0d.w0", k), 12'd0, 32'd1);
      cyc(1, 0, 32'd2);
      chk_write($sformatf("ck%0d.w1", k), 12'd1, 32'd2);
      chk_flags($sformatf("ck%0d.check", k), 1'b1, 1'b1, 1'b0, 1'b0);
      cyc(0, 0, 32'd0);
      chk_flags($sformatf("ck%0d.wait", k), 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1, 0, 32'(3 + k));
      chk_flags($sformatf("ck%0d.end", k), 1'b0, 1'b0, 1'b1, k == 1);
      cyc(0, 1, 32'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Consumes the 32-bit word stream produced by the byte-to-word concatenation stage on the UART receive path. Writes a length-prefixed program image into instruction memory.
- First word received is the image length N in words; the next N words go to consecutive instruction-memory addresses starting at 0.
- Signals completion to the core-release logic, which holds the core in reset until done.

Parameters:
DATAW, 32, width of incoming words and memory write data
ADDRW, 12, instruction-memory word-address width; capacity 2^ADDRW words

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
din  input  DATAW  word from concatenation stage
valid  input  1  one-cycle pulse: din holds a complete word
restart  input  1  one-cycle pulse: re-arm loader after DONE
we  output  1  instruction-memory write enable, one cycle per word
waddr  output  ADDRW  instruction-memory word address
wdata  output  DATAW  instruction-memory write data
busy  output  1  high in LOAD and CHECK states
done  output  1  high in DONE state (sticky)
err  output  1  error flag, valid while done=1

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; we=0, waddr=0, wdata=0, busy=0, done=0, err=0.
  - Word counter=0, remaining=0, accumulator=0.
- States: IDLE, LOAD, CHECK (checksum build only), DONE. All outputs registered.
- IDLE:
  - On valid, latch din as N.
  - N=0 -> DONE, err=0, no writes.
  - N>2^ADDRW -> DONE, err=1, no writes.
  - Otherwise -> LOAD, remaining=N, counter=0.
  - valid absent -> hold.
- LOAD:
  - On each valid: cycle after valid, we=1, waddr=counter, wdata=din; then counter+1, remaining-1.
  - Accepts valid on every cycle, back-to-back; write latency is exactly 1 cycle.
  - The write of the final word (remaining=1) is issued together with the transition to CHECK (checksum build) or DONE. done rises in the same cycle that the last we pulse is visible.
  - Counter width ADDRW+1; N=2^ADDRW writes addresses 0..2^ADDRW-1 with no wrap.
- DONE:
  - done=1, busy=0, we=0.
  - valid ignored; no writes, no state change.
  - restart -> IDLE, clear done/err/counter/accumulator.
  - restart in any other state is ignored.
- valid and restart in the same cycle in DONE: restart wins, and the word is dropped.
- Reset mid-load aborts immediately. Memory contents already written are not touched, and the next word received after reset is treated as the length.
- we is never high outside LOAD or the cycle leaving LOAD.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined:
  - Accumulator = modulo-2^DATAW sum of the N payload words.
  - After the last payload word the loader enters CHECK and waits for one more valid word, which is not written.
  - Mismatch -> DONE, err=1; match -> DONE, err=0. busy stays high in CHECK.
  - N=0 skips CHECK.
- Not defined:
  - No accumulator or CHECK state.
  - LOAD goes straight to DONE after the last word.
  - err is set only by oversize N.

Test Plan:
- Reset, then words 3, 0xA, 0xB, 0xC back-to-back on valid -> writes (0,0xA),(1,0xB),(2,0xC) one cycle after each valid; done=1 and err=0 in the cycle of the last write.
- Length 0 -> done=1 next cycle, err=0, we never asserted; later valid words produce no writes.
- Length 2^ADDRW+1 (4097) -> done=1, err=1, no writes. Then restart, then length 1 and word 0x55 -> write (0,0x55), err=0.
- Length 4, two payload words, then rst=0 mid-stream -> all outputs 0 asynchronously. After release, length 1 and word 0x7 -> write (0,0x7).
- Gapped valids (idle gaps of 0-5 cycles) for length 5 -> five writes at addresses 0..4, exact data; busy=1 throughout, done only after the fifth.
- With PROG_LOADER_CHECKSUM_EN: length 2, words 1 and 2, checksum 3 -> err=0. Repeat with checksum 4 -> err=1. In both cases the checksum word is not written and busy=1 until it arrives.
